// File: rtl/ssd_cnt_disp.sv
// Rising-edge counter of seq_jug into a 2-digit BCD count, shown on a multiplexed
// common-anode 7-segment display. Define DET_CNT_SAT_EN to saturate at 99 (sticky ovf).
module ssd_cnt_disp #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seq_jug,
  input  logic       clr,
  output logic [7:0] cnt_bcd,
  output logic       ovf,
  output logic [7:0] seg,
  output logic [1:0] an
);

  localparam logic [CNT_W-1:0] ScanLast = CNT_W'(SCAN_DIV - 1);

  logic             jug_q;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] scan_q, scan_d;
  logic             dig_q, dig_d;
  logic             inc;
  logic             scan_wrap;
  logic [3:0]       digit;

  function automatic logic [6:0] decode7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign inc = seq_jug & ~jug_q;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
`ifdef DET_CNT_SAT_EN
    ovf_d  = ovf_q;
`else
    ovf_d  = 1'b0;  // single-cycle pulse
`endif
    if (clr) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
      ovf_d  = 1'b0;
    end else if (inc) begin
      if (ones_q < 4'd9) begin
        ones_d = ones_q + 4'd1;
      end else if (tens_q < 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
`ifdef DET_CNT_SAT_EN
        ovf_d  = 1'b1;
`else
        ones_d = 4'd0;
        tens_d = 4'd0;
        ovf_d  = 1'b1;
`endif
      end
    end
  end

  assign scan_wrap = (scan_q == ScanLast);

  always_comb begin
    scan_d = scan_wrap ? '0 : scan_q + CNT_W'(1);
    dig_d  = dig_q ^ scan_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jug_q  <= 1'b0;
      tens_q <= 4'd0;
      ones_q <= 4'd0;
      ovf_q  <= 1'b0;
      scan_q <= '0;
      dig_q  <= 1'b0;
    end else begin
      jug_q  <= seq_jug;
      tens_q <= tens_d;
      ones_q <= ones_d;
      ovf_q  <= ovf_d;
      scan_q <= scan_d;
      dig_q  <= dig_d;
    end
  end

  assign digit   = dig_q ? tens_q : ones_q;
  assign seg     = {1'b1, decode7(digit)};
  assign an      = dig_q ? 2'b01 : 2'b10;
  assign cnt_bcd = {tens_q, ones_q};
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_ssd_cnt_disp.sv
// Directed bench for ssd_cnt_disp with SCAN_DIV=4; define DET_CNT_SAT_EN for the
// saturating build.
module tb_ssd_cnt_disp;

  logic       clk;
  logic       rst_n;
  logic       seq_jug;
  logic       clr;
  logic [7:0] cnt_bcd;
  logic       ovf;
  logic [7:0] seg;
  logic [1:0] an;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  ssd_cnt_disp #(
    .SCAN_DIV(4),
    .CNT_W   (16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .seq_jug(seq_jug),
    .clr    (clr),
    .cnt_bcd(cnt_bcd),
    .ovf    (ovf),
    .seg    (seg),
    .an     (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Digit n stays lit for cycles [4n, 4n+3] after reset release.
  task automatic disp_scan(input int t, input int o);
    int d;
    repeat (8) begin
      d = (cyc / 4) % 2;
      chk("an", 32'(an), (d == 1) ? 32'h1 : 32'h2);
      chk("seg", 32'(seg), 32'(seg_tab[(d == 1) ? t : o]));
      tick();
    end
  endtask

  task automatic pulse(input int len);
    seq_jug = 1'b1;
    repeat (len) tick();
    seq_jug = 1'b0;
    tick();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    seq_jug = 1'b0;
    clr     = 1'b0;
    repeat (3) tick();

    // 1. Reset state and idle scan
    chk("rst_cnt", 32'(cnt_bcd), 32'h00);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_an", 32'(an), 32'h2);
    chk("rst_seg", 32'(seg), 32'hC0);
    rst_n = 1'b1;
    cyc   = 0;
    disp_scan(0, 0);
    chk("idle_cnt", 32'(cnt_bcd), 32'h00);
    chk("idle_ovf", 32'(ovf), 32'h0);

    // 2. Held level counts once per rising edge
    seq_jug = 1'b1;
    tick();
    chk("latency", 32'(cnt_bcd), 32'h01);
    repeat (4) tick();
    seq_jug = 1'b0;
    tick();
    chk("held_once", 32'(cnt_bcd), 32'h01);
    pulse(5);
    pulse(5);
    chk("cnt3", 32'(cnt_bcd), 32'h03);
    disp_scan(0, 3);

    // 3. Twelve single-cycle pulses, carry into tens
    do_clr();
    chk("clr0", 32'(cnt_bcd), 32'h00);
    repeat (9) pulse(1);
    chk("cnt9", 32'(cnt_bcd), 32'h09);
    pulse(1);
    chk("carry10", 32'(cnt_bcd), 32'h10);
    pulse(1);
    pulse(1);
    chk("cnt12", 32'(cnt_bcd), 32'h12);
    disp_scan(1, 2);

    // 4. clr wins over a simultaneous rising edge
    do_clr();
    repeat (7) pulse(1);
    chk("cnt7", 32'(cnt_bcd), 32'h07);
    seq_jug = 1'b1;
    clr     = 1'b1;
    tick();
    chk("clr_prio", 32'(cnt_bcd), 32'h00);
    clr = 1'b0;
    tick();
    chk("clr_jug_upd", 32'(cnt_bcd), 32'h00);
    seq_jug = 1'b0;
    tick();

    // 5. 100 pulses from 00
    do_clr();
    repeat (99) pulse(1);
    chk("cnt99", 32'(cnt_bcd), 32'h99);
    chk("ovf99", 32'(ovf), 32'h0);
    disp_scan(9, 9);
    seq_jug = 1'b1;
    tick();
`ifdef DET_CNT_SAT_EN
    chk("sat_cnt", 32'(cnt_bcd), 32'h99);
    chk("sat_ovf", 32'(ovf), 32'h1);
    seq_jug = 1'b0;
    tick();
    pulse(1);
    chk("sat_hold_cnt", 32'(cnt_bcd), 32'h99);
    chk("sat_hold_ovf", 32'(ovf), 32'h1);
    do_clr();
    chk("sat_clr_cnt", 32'(cnt_bcd), 32'h00);
    chk("sat_clr_ovf", 32'(ovf), 32'h0);
`else
    chk("wrap_cnt", 32'(cnt_bcd), 32'h00);
    chk("wrap_ovf", 32'(ovf), 32'h1);
    seq_jug = 1'b0;
    tick();
    chk("wrap_ovf_end", 32'(ovf), 32'h0);
    chk("wrap_cnt_hold", 32'(cnt_bcd), 32'h00);
    pulse(1);
    chk("wrap_next", 32'(cnt_bcd), 32'h01);
`endif

    // 6. Asynchronous reset mid-count
    do_clr();
    repeat (45) pulse(1);
    chk("cnt45", 32'(cnt_bcd), 32'h45);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(cnt_bcd), 32'h00);
    chk("arst_ovf", 32'(ovf), 32'h0);
    chk("arst_an", 32'(an), 32'h2);
    chk("arst_seg", 32'(seg), 32'hC0);
    tick();
    tick();
    rst_n = 1'b1;
    cyc   = 0;
    disp_scan(0, 0);
    pulse(1);
    chk("post_rst_cnt", 32'(cnt_bcd), 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
